motion_pi_cntrl: RTL and testbench
==================================

Name: motion_pi_cntrl

Overview:
- Upstream neighbour of motor_cntrl in the line follower.
- Converts each line-position error sample into signed 11-bit left/right motor commands using a saturating PI law around a base speed.
- Outputs feed motor_cntrl lft/rht directly.
- Multi-cycle sequential datapath: one error sample is in flight at a time, with a busy/update handshake.

Parameters:
- BASE_SPD, 300, signed base forward speed applied to both wheels (legal range -1023..1023).
- KP, 3, unsigned 4-bit proportional gain.
- KI_SHIFT, 4, integral term scaling: integrator is arithmetic-right-shifted by KI_SHIFT.
- INT_LIM, 4095, symmetric saturation limit of the integrator magnitude.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- go  input  1  level enable; 0 forces brake/zero commands.
- err_vld  input  1  single-cycle strobe; err is valid this cycle.
- err  input  12  signed error; positive = line right of centre.
- lft  output  11  signed left motor command to motor_cntrl.
- rht  output  11  signed right motor command to motor_cntrl.
- busy  output  1  high while a sample is being processed.
- upd  output  1  single-cycle pulse when lft/rht take new values.

Behaviour:
- Reset (async, rst_n=0):
  - lft=0, rht=0, busy=0, upd=0.
  - Integrator=0, captured error=0, FSM in IDLE.
- FSM states: IDLE -> INTEG -> PTERM -> SUM -> OUT -> IDLE.
- IDLE:
  - If err_vld=1 and go=1, register err into err_q, set busy=1, go to INTEG.
  - Otherwise stay in IDLE.
- INTEG: integ = clamp(integ + err_q, -INT_LIM, +INT_LIM). Integrator is 14-bit signed with a full-width sum before the clamp.
- PTERM: pterm = clamp(err_q * KP, -1023, +1023). The product is 16-bit signed.
- SUM: corr = clamp(pterm + (integ >>> KI_SHIFT), -1023, +1023). The shift is arithmetic and floors, so -100>>>4 = -7.
- OUT (single registered update, same edge):
  - lft = clamp(BASE_SPD + corr, -1023, +1023).
  - rht = clamp(BASE_SPD - corr, -1023, +1023).
  - upd=1 for exactly the following cycle; busy=0; return to IDLE.
- Latency: the edge that samples err_vld is edge 0. lft/rht/upd change on edge 4. busy is high from edge 0 through edge 4.
- Clamps are symmetric; -1024 is never output.
- All intermediate arithmetic is sign-extended with no wrap-around.
- err_vld while busy=1: the sample is dropped. No queueing, no effect on state.
- go=0 at any time, including mid-calculation:
  - On the next edge, FSM goes to IDLE; lft=0, rht=0, integrator=0, busy=0.
  - No upd pulse is issued for the aborted sample.
  - err_vld is ignored while go=0.
  - lft=rht=0 makes motor_cntrl brake.
- go=1 and err_vld=1 in the same cycle that go rises: the sample is accepted.
- Mid-operation async reset: immediate return to reset values, with no upd pulse.
- lft/rht hold their last value between updates. upd is never high for more than one cycle.

Test Plan:
Bench uses default parameters; each case starts from reset unless stated.
1. go=1, err=0 with err_vld pulse -> edge 4: lft=300, rht=300, upd high one cycle; busy high for edges 0-4.
2. go=1, err=+100 pulse -> integ=100, pterm=300, corr=306 -> lft=606, rht=-6.
3. go=1, err=-100 pulse -> integ=-100, corr=-307 -> lft=-7, rht=607.
4. go=1, err=+2000 pulsed three times (each after upd):
   - integ sequence 2000, 4000, 4095 (clamped).
   - Every result is lft=1023, rht=-723.
   - Outputs never exceed +/-1023.
5. err=+100 pulse, then go=0 two cycles later:
   - No upd; lft=rht=0 and integ=0 one edge after go falls.
   - Then go=1 and err=0 pulse -> lft=rht=300.
6. err=+100 pulse, then err=+500 pulse one cycle later while busy -> exactly one upd pulse, with lft=606, rht=-6. The second sample is dropped and the integrator stays at 100.

Source files
------------

// File: rtl/motion_pi_cntrl.sv
// motion_pi_cntrl: saturating PI controller turning line-position error into left/right motor commands.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   go            level enable; low brakes (zero commands) and clears the integrator
//   err_vld, err  single-cycle strobe with signed 12-bit error (positive = line right of centre)
//   lft, rht      signed 11-bit motor commands, held between updates
//   busy          high while a sample is in flight
//   upd           one-cycle pulse when lft/rht take new values
module motion_pi_cntrl #(
  parameter int BASE_SPD = 300,
  parameter int KP       = 3,
  parameter int KI_SHIFT = 4,
  parameter int INT_LIM  = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        err_vld,
  input  logic [11:0] err,
  output logic [10:0] lft,
  output logic [10:0] rht,
  output logic        busy,
  output logic        upd
);
  typedef enum logic [2:0] {IDLE, INTEG, PTERM, SUM, OUT} state_t;
  localparam logic signed [16:0] LIM11 = 17'sd1023;
  localparam logic signed [16:0] ILIM  = 17'(INT_LIM);
  localparam logic signed [16:0] BASE  = 17'(BASE_SPD);
  localparam logic signed [15:0] KP_S  = 16'(KP);
  // All datapath values are widened to 17 bits so every sum is exact before saturation.
  function automatic logic signed [16:0] sat(input logic signed [16:0] v, input logic signed [16:0] lim);
    return (v > lim) ? lim : (v < -lim) ? -lim : v;
  endfunction
  state_t state_q, state_d;
  logic signed [11:0] err_q;
  logic signed [13:0] integ_q, integ_d;
  logic signed [10:0] pterm_q, pterm_d, corr_q, corr_d, lft_q, lft_d, rht_q, rht_d;
  logic signed [15:0] prod;
  logic               upd_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (!go) state_d = IDLE;
    else
      case (state_q)
        IDLE:    state_d = err_vld ? INTEG : IDLE;
        INTEG:   state_d = PTERM;
        PTERM:   state_d = SUM;
        SUM:     state_d = OUT;
        default: state_d = IDLE;
      endcase
  end
  always_comb begin
    busy = state_q != IDLE;
    upd  = upd_q;
    lft  = lft_q;
    rht  = rht_q;
  end
  always_comb begin
    prod    = 16'(err_q) * KP_S;
    integ_d = 14'(sat(17'(integ_q) + 17'(err_q), ILIM));
    pterm_d = 11'(sat(17'(prod), LIM11));
    corr_d  = 11'(sat(17'(pterm_q) + 17'(integ_q >>> KI_SHIFT), LIM11));
    lft_d   = 11'(sat(BASE + 17'(corr_q), LIM11));
    rht_d   = 11'(sat(BASE - 17'(corr_q), LIM11));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err_q   <= '0;
      integ_q <= '0;
      pterm_q <= '0;
      corr_q  <= '0;
      lft_q   <= '0;
      rht_q   <= '0;
      upd_q   <= 1'b0;
    end else if (!go) begin
      integ_q <= '0;
      lft_q   <= '0;
      rht_q   <= '0;
      upd_q   <= 1'b0;
    end else begin
      upd_q <= state_q == OUT;
      case (state_q)
        IDLE:    if (err_vld) err_q <= err;
        INTEG:   integ_q <= integ_d;
        PTERM:   pterm_q <= pterm_d;
        SUM:     corr_q <= corr_d;
        default: begin
          lft_q <= lft_d;
          rht_q <= rht_d;
        end
      endcase
    end
endmodule

// File: tb/tb_motion_pi_cntrl.sv
// tb_motion_pi_cntrl: directed self-checking bench for motion_pi_cntrl.
module tb_motion_pi_cntrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic        err_vld = 1'b0;
  logic [11:0] err = '0;
  logic [10:0] lft, rht;
  logic        busy, upd;
  int          total = 0;
  int          bad = 0;
  always #5 clk = ~clk;
  motion_pi_cntrl dut (
    .clk(clk), .rst_n(rst_n), .go(go), .err_vld(err_vld), .err(err),
    .lft(lft), .rht(rht), .busy(busy), .upd(upd)
  );
  task automatic chk(input string t, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", t, got, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0; go = 1'b0; err_vld = 1'b0; err = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    go = 1'b1;
  endtask
  task automatic run(input string t, input int e, input int el, input int er);
    int n;
    @(negedge clk);
    err = 12'(e); err_vld = 1'b1;
    @(negedge clk);
    err_vld = 1'b0;
    chk({t, ".busy_e0"}, int'(busy), 1);
    n = 0;
    while (!upd && n < 10) begin
      @(negedge clk);
      n++;
      if (n < 4) chk({t, ".busy_mid"}, int'(busy), 1);
    end
    chk({t, ".lat"}, n, 4);
    chk({t, ".lft"}, int'($signed(lft)), el);
    chk({t, ".rht"}, int'($signed(rht)), er);
    chk({t, ".busy_e4"}, int'(busy), 0);
    @(negedge clk);
    chk({t, ".upd_1cyc"}, int'(upd), 0);
  endtask
  initial begin
    int cnt;
    #1;
    chk("rst.lft", int'(lft), 0);
    chk("rst.rht", int'(rht), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.upd", int'(upd), 0);
    do_reset();
    run("zero", 0, 300, 300);
    do_reset();
    run("pos100", 100, 606, -6);
    // go drops mid-calculation (continues from previous case so outputs are nonzero)
    @(negedge clk);
    err = 12'd100; err_vld = 1'b1;
    @(negedge clk);
    err_vld = 1'b0;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    chk("abort.lft", int'($signed(lft)), 0);
    chk("abort.rht", int'($signed(rht)), 0);
    chk("abort.busy", int'(busy), 0);
    cnt = 0;
    repeat (6) begin
      if (upd) cnt++;
      @(negedge clk);
    end
    chk("abort.no_upd", cnt, 0);
    // go rises together with err_vld: sample accepted, integrator was cleared
    go = 1'b1;
    run("rego", 0, 300, 300);
    do_reset();
    run("neg100", -100, -7, 607);
    do_reset();
    run("big1", 2000, 1023, -723);
    run("big2", 2000, 1023, -723);
    run("big3", 2000, 1023, -723);
    // integrator held at 4095: 2095>>>4=130, corr=-1023+130=-893
    run("unwind", -2000, -593, 1023);
    do_reset();
    @(negedge clk);
    err = 12'd100; err_vld = 1'b1;
    @(negedge clk);
    err = 12'd500;
    @(negedge clk);
    err_vld = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (upd) begin
        cnt++;
        chk("drop.lft", int'($signed(lft)), 606);
        chk("drop.rht", int'($signed(rht)), -6);
      end
    end
    chk("drop.upd_cnt", cnt, 1);
    run("drop.integ", 0, 306, 294);
    // asynchronous reset mid-calculation
    @(negedge clk);
    err = 12'd100; err_vld = 1'b1;
    @(negedge clk);
    err_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst.lft", int'(lft), 0);
    chk("arst.busy", int'(busy), 0);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (upd) cnt++;
    end
    chk("arst.no_upd", cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
